count_ctrl: RTL

Sequencing controller for the modulo-10 up/down counter (`count`). It drives the counter's ENABLE and UP_DOWN inputs and watches its TC output. It runs a programmed number of full counter passes, supports pause, resume and abort, and signals completion. It sits between the user-facing start/stop controls and one `count` instance; the controller output ports connect directly to that instance's ports.

---
 rtl/count_pkg.sv | 14 +
 rtl/count_ctrl.sv | 101 ++++++++++
 2 files changed

// File: rtl/count_pkg.sv
// rtl/count_pkg.sv - shared state encoding and sizes for the count sequencing controller
package count_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSE  = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam int MODULO = 10;
    localparam int PASS_W = 4;

endpackage

// File: rtl/count_ctrl.sv
// rtl/count_ctrl.sv - pass sequencer for the modulo-10 counter (run/pause/abort/done)
// Optional feature macro: ALT_DIR_EN (alternate counting direction on every non-final pass)
module count_ctrl
    import count_pkg::*;
#(
    parameter int PASSES    = 4,
    parameter bit START_DIR = 1'b1
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              START,
    input  logic              STOP,
    input  logic              CNT_TC,
    output logic              CNT_ENABLE,
    output logic              CNT_UP_DOWN,
    output logic              BUSY,
    output logic              DONE,
    output logic              ABORTED,
    output logic [PASS_W-1:0] PASS_LEFT
);

    state_t            state, state_n;
    logic              enable_n, up_down_n, done_n, aborted_n;
    logic [PASS_W-1:0] pass_left_n;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state       <= IDLE;
            CNT_ENABLE  <= 1'b0;
            CNT_UP_DOWN <= START_DIR;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            ABORTED     <= 1'b0;
            PASS_LEFT   <= '0;
        end else begin
            state       <= state_n;
            CNT_ENABLE  <= enable_n;
            CNT_UP_DOWN <= up_down_n;
            BUSY        <= (state_n == RUN) || (state_n == PAUSE);
            DONE        <= done_n;
            ABORTED     <= aborted_n;
            PASS_LEFT   <= pass_left_n;
        end
    end

    always_comb begin
        state_n     = state;
        enable_n    = CNT_ENABLE;
        up_down_n   = CNT_UP_DOWN;
        done_n      = 1'b0;
        aborted_n   = 1'b0;
        pass_left_n = PASS_LEFT;
        case (state)
            IDLE: begin
                if (START && !STOP) begin
                    state_n     = RUN;
                    pass_left_n = PASS_W'(PASSES);
                    up_down_n   = START_DIR;
                    enable_n    = 1'b1;
                end
            end
            RUN: begin
                if (CNT_TC && PASS_LEFT == PASS_W'(1)) begin
                    state_n     = FINISH;
                    enable_n    = 1'b0;
                    pass_left_n = '0;
                    done_n      = 1'b1;
                end else if (CNT_TC) begin
                    // A TC coinciding with STOP is still counted: the counter already stepped.
                    pass_left_n = (PASS_LEFT != '0) ? PASS_LEFT - PASS_W'(1) : '0;
`ifdef ALT_DIR_EN
                    up_down_n   = ~CNT_UP_DOWN;
`endif
                    if (STOP) begin
                        state_n  = PAUSE;
                        enable_n = 1'b0;
                    end
                end else if (STOP) begin
                    state_n  = PAUSE;
                    enable_n = 1'b0;
                end
            end
            PAUSE: begin
                if (STOP) begin
                    state_n     = IDLE;
                    aborted_n   = 1'b1;
                    pass_left_n = '0;
                    up_down_n   = START_DIR;
                end else if (START) begin
                    state_n  = RUN;
                    enable_n = 1'b1;
                end
            end
            default: begin
                state_n  = IDLE;
                enable_n = 1'b0;
            end
        endcase
    end

endmodule
